// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state, parity encodings and prescale floor for the UART receiver.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    localparam int PRESCALE_MIN = 4;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser, per-bit edge counter and bit sampling.
// UART_RX_MAJ_VOTE_EN selects 2-of-3 majority around mid-bit instead of a single mid sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  line,
    output logic                  sample,
    output logic                  bit_val,
    output logic                  bit_end
);
    logic [1:0] sync;
    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] mid;
    assign mid = prescale >> 1;
    assign line = sync[1];
    assign bit_end = run && cnt == prescale - 1'b1;
`ifdef UART_RX_MAJ_VOTE_EN
    logic [1:0] hist;
    assign sample = run && cnt == mid + 1'b1;
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
    always_ff @(posedge clk)
        if (rst) hist <= 2'b11;
        else hist <= {hist[0], line};
`else
    assign sample = run && cnt == mid;
    assign bit_val = line;
`endif
    always_ff @(posedge clk)
        if (rst) begin
            sync <= 2'b11;
            cnt <= '0;
        end else begin
            sync <= {sync[0], rx_in};
            cnt <= (!run || bit_end) ? '0 : cnt + 1'b1;
        end
endmodule

// File: rtl/uart_rx_frame_engine.sv
// uart_rx_frame_engine: UART frame receiver with parity/framing checks and a valid/ready output register.
// Optional UART_RX_MAJ_VOTE_EN enables majority-vote bit sampling in the sampler.
module uart_rx_frame_engine
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_par_err,
    output logic                  m_frm_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ovr_err,
    output logic                  busy
);
    state_t state;
    logic [PRESCALE_W-1:0] p_q;
    logic par_en_q, par_typ_q, stop2_q;
    logic [3:0] bit_cnt;
    logic [DATA_W-1:0] sh;
    logic par_err, frm_err;
    logic line, sample, smp_bit, bit_end, done;
    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk(clk), .rst(rst), .rx_in(rx_in), .run(state != IDLE), .prescale(p_q),
        .line(line), .sample(sample), .bit_val(smp_bit), .bit_end(bit_end)
    );
    assign busy = state != IDLE;
    // The frame completes at the sample of the last stop bit, not at its end.
    assign done = state == STOP && sample && bit_cnt == {3'b0, stop2_q};
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            p_q <= '0;
            par_en_q <= 1'b0;
            par_typ_q <= PAR_EVEN;
            stop2_q <= 1'b0;
            bit_cnt <= '0;
            sh <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            m_data <= '0;
            m_par_err <= 1'b0;
            m_frm_err <= 1'b0;
            m_valid <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (!line) begin
                        state <= START;
                        p_q <= prescale < PRESCALE_W'(PRESCALE_MIN) ? PRESCALE_W'(PRESCALE_MIN) : prescale;
                        par_en_q <= par_en;
                        par_typ_q <= par_typ;
                        stop2_q <= stop2;
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                START:
                    if (sample && smp_bit) state <= IDLE;
                    else if (bit_end) state <= DATA;
                DATA: begin
                    if (sample) sh <= {smp_bit, sh[DATA_W-1:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt == 4'(DATA_W - 1) ? 4'd0 : bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_W - 1)) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sample) par_err <= smp_bit ^ (^sh) ^ (par_typ_q == PAR_ODD);
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (sample && !smp_bit) frm_err <= 1'b1;
                    if (done) state <= IDLE;
                    else if (bit_end) bit_cnt <= bit_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
            if (done && (!m_valid || m_ready)) begin
                m_data <= sh;
                m_par_err <= par_err;
                m_frm_err <= frm_err | !smp_bit;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) m_valid <= 1'b0;
            ovr_err <= done && m_valid && !m_ready;
        end
endmodule

// File: doc/uart_rx_frame_engine.md
# uart_rx_frame_engine

Parametrised second-generation UART receiver: recovers frames with DATA_W data bits, optional even/odd parity and one or two stop bits from an oversampled serial line, at a runtime-selectable prescale. Delivers each frame over a valid/ready output port with per-frame parity and framing flags, plus an overrun pulse when the consumer stalls. Sits between the pad-side RX line and the register/FIFO layer of the UART subsystem.

## Interface
- DATA_W, 8: data bits per frame; legal 5..9.
- PRESCALE_W, 6: width of prescale input; clocks per bit up to 2^PRESCALE_W-1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rx_in  in  1  serial line, idle high, asynchronous to clk.
- prescale  in  PRESCALE_W  clocks per bit; values below 4 are treated as 4.
- par_en  in  1  parity bit present.
- par_typ  in  1  0 = even, 1 = odd.
- stop2  in  1  1 = two stop bits expected.
- m_data  out  DATA_W  received data, LSB first on line.
- m_par_err  out  1  parity mismatch; qualified by m_valid.
- m_frm_err  out  1  a stop bit sampled low; qualified by m_valid.
- m_valid  out  1  frame available.
- m_ready  in  1  consumer accepts.
- ovr_err  out  1  one-cycle pulse: completed frame dropped.
- busy  out  1  FSM not in IDLE.

## Operation
- rx_in passes a 2-flop synchroniser (reset value 1); all logic uses the synchronised line.
- Config latch: prescale (clamped), par_en, par_typ, stop2 captured on the cycle leaving IDLE; changes mid-frame are ignored.
- Edge counter runs 0..P-1 per bit, P = latched prescale; sample point MID = P>>1.
- FSM: IDLE -> START when synchronised line = 0. START: at sample point, line 1 -> IDLE (glitch, nothing output); 0 -> DATA at bit end. DATA: DATA_W bits, shift in LSB first; -> PARITY if par_en else STOP. PARITY: compare sampled bit with XOR of data (XOR par_typ), set parity error flag. STOP: sample one or two stop bits; any 0 sets framing error. The frame completes at the sample point of the last stop bit; the FSM then goes to IDLE immediately and can detect the next start edge, so it resynchronises within half a bit.
- Output register: on completion, if !m_valid or (m_valid and m_ready) in the same cycle, load m_data/m_par_err/m_frm_err and set m_valid. Otherwise keep the old contents, drop the new frame and pulse ovr_err.
- m_valid clears on m_valid and m_ready when no new frame is loading.
- Frames with errors are still delivered, with their flags set.

## Timing
- Reset values: m_data 0, m_par_err 0, m_frm_err 0, m_valid 0, ovr_err 0, busy 0, FSM IDLE, synchroniser 1.
- Reset mid-frame aborts the frame with no output; reset has priority over a same-cycle completion.
- Start detection lags the rx_in falling edge by 2 cycles (synchroniser).
- m_valid rises on the cycle after the final sample cycle of the last stop bit. Sample cycle = MID, or MID+1 when majority voting is enabled.
- ovr_err is high on that same cycle, for exactly 1 cycle.
- busy is high from the START entry cycle through the completion cycle.

## Configuration
- UART_RX_MAJ_VOTE_EN defined:
  - Each bit is the 2-of-3 majority of samples at edge counts MID-1, MID and MID+1.
  - The start-bit glitch check uses the majority value.
- Not defined:
  - A single sample at MID.
  - Completion is one cycle earlier.

## Structure
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN / PAR_ODD constants;
  - PRESCALE_MIN = 4.
- Sub-module uart_rx_sampler contains the synchroniser, edge counter and sample/majority logic. It outputs a sample strobe, the sampled bit and a bit-end strobe.
- The top holds the FSM, bit counter, shift register, checks and output register.

## Test plan
- Basic frame: DATA_W=8, P=8, no parity, 1 stop, send 0xA5 with m_ready=1 -> m_data=0xA5, m_par_err=0, m_frm_err=0, one m_valid cycle.
- Parity: P=16, par_en=1, par_typ=0:
  - send 0x07 with parity bit 1 -> m_par_err=0;
  - resend 0x07 with parity bit 0 -> m_par_err=1, m_data=0x07.
- Framing and stop2: stop2=1, send 0x3C with second stop bit low -> m_frm_err=1. Next frame 0x55 is received cleanly.
- Start glitch: pulse rx_in low for 2 clocks at P=16 -> FSM returns to IDLE, no m_valid, busy drops.
- Backpressure: m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, ovr_err pulses once. Raise m_ready -> m_valid clears.
- Reset mid-frame: assert rst during the data bits of 0xF0 -> all outputs 0, no m_valid. Next frame 0x81 is received correctly.
